pwd_cand_gen: RTL and testbench

PWD_CAND_GEN -- requirements
Module: pwd_cand_gen

---
 rtl/pwd_pkg.sv | 30 +++
 rtl/bcd_add8.sv | 26 ++
 rtl/pwd_cand_gen.sv | 114 +++++++++++
 tb/tb_pwd_cand_gen.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwd_pkg.sv
// Shared definitions for the password candidate generator: digit count,
// ASCII offset, FSM state encoding and BCD helper functions.
package pwd_pkg;

    localparam int         BCD_DIGITS = 8;
    localparam logic [7:0] ASCII_ZERO = 8'h30;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_RUN  = 3'b010,
        ST_DONE = 3'b100
    } state_t;

    function automatic logic [8*BCD_DIGITS-1:0] bcd_to_ascii(input logic [4*BCD_DIGITS-1:0] bcd);
        logic [8*BCD_DIGITS-1:0] r;
        r = '0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            r[8*i +: 8] = ASCII_ZERO + {4'h0, bcd[4*i +: 4]};
        end
        return r;
    endfunction

    function automatic bit bcd_is_legal(input logic [4*BCD_DIGITS-1:0] v);
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

endpackage

// File: rtl/bcd_add8.sv
// Combinational 8-digit packed-BCD adder with decimal carry between digits
// and a carry out of the most significant digit.
module bcd_add8
    import pwd_pkg::*;
(
    input  logic [4*BCD_DIGITS-1:0] a,
    input  logic [4*BCD_DIGITS-1:0] b,
    output logic [4*BCD_DIGITS-1:0] sum,
    output logic                    cout
);

    logic [BCD_DIGITS:0] carry;

    assign carry[0] = 1'b0;

    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
        logic [4:0] raw;
        assign raw = {1'b0, a[4*gi +: 4]} + {1'b0, b[4*gi +: 4]} + {4'b0, carry[gi]};
        assign carry[gi+1] = (raw > 5'd9);
        // Adding 6 to a result above 9 wraps the nibble to raw - 10.
        assign sum[4*gi +: 4] = carry[gi+1] ? (raw[3:0] + 4'd6) : raw[3:0];
    end

    assign cout = carry[BCD_DIGITS];

endmodule

// File: rtl/pwd_cand_gen.sv
// Packed-BCD password candidate generator: walks START..END in STRIDE steps,
// presenting each candidate over a valid/ready handshake in BCD and ASCII.
module pwd_cand_gen
    import pwd_pkg::*;
#(
    parameter logic [31:0] START_BCD  = 32'h00000000,
    parameter logic [31:0] END_BCD    = 32'h99999999,
    parameter logic [31:0] STRIDE_BCD = 32'h00000001
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stop,
    output logic        cand_valid,
    input  logic        cand_ready,
    output logic [31:0] cand_bcd,
    output logic [63:0] cand_ascii,
    output logic        busy,
    output logic        exhausted,
    output logic [31:0] issued_count
);

    localparam bit PARAMS_LEGAL = bcd_is_legal(START_BCD) && bcd_is_legal(END_BCD)
                               && bcd_is_legal(STRIDE_BCD) && (START_BCD <= END_BCD)
                               && (STRIDE_BCD != 32'h0);

    param_check: assert property (@(posedge clk) PARAMS_LEGAL)
        else $error("pwd_cand_gen: illegal BCD parameters");

    state_t      state_reg, state_next;
    logic [31:0] cur_reg, cur_next;
    logic [31:0] cnt_reg, cnt_next;
    logic        exh_reg, exh_next;

    logic [31:0] cur_sum;
    logic        cur_cout;
    logic [31:0] cnt_sum;
    logic        cnt_carry_unused;
    logic        handshake;
    logic        next_in_range;

    bcd_add8 u_next_add (
        .a    (cur_reg),
        .b    (STRIDE_BCD),
        .sum  (cur_sum),
        .cout (cur_cout)
    );

    // Counter wraps 99999999 -> 0, so its carry out is deliberately dropped.
    bcd_add8 u_cnt_add (
        .a    (cnt_reg),
        .b    (32'h00000001),
        .sum  (cnt_sum),
        .cout (cnt_carry_unused)
    );

    assign handshake     = (state_reg == ST_RUN) && cand_ready;
    // Binary magnitude order matches decimal order for legal packed BCD.
    assign next_in_range = !cur_cout && (cur_sum <= END_BCD);

    always_comb begin
        state_next = state_reg;
        cur_next   = cur_reg;
        cnt_next   = cnt_reg;
        exh_next   = exh_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = ST_RUN;
                    cur_next   = START_BCD;
                    cnt_next   = '0;
                    exh_next   = 1'b0;
                end
            end
            ST_RUN: begin
                if (handshake) cnt_next = cnt_sum;
                if (stop) begin
                    state_next = ST_DONE;
                    exh_next   = 1'b0;
                end else if (handshake) begin
                    if (next_in_range) begin
                        cur_next = cur_sum;
                    end else begin
                        state_next = ST_DONE;
                        exh_next   = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            cur_reg   <= START_BCD;
            cnt_reg   <= '0;
            exh_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cur_reg   <= cur_next;
            cnt_reg   <= cnt_next;
            exh_reg   <= exh_next;
        end
    end

    assign cand_valid   = (state_reg == ST_RUN);
    assign busy         = (state_reg == ST_RUN);
    assign exhausted    = exh_reg;
    assign issued_count = cnt_reg;
    assign cand_bcd     = cur_reg;
    assign cand_ascii   = bcd_to_ascii(cur_reg);

endmodule

// File: tb/tb_pwd_cand_gen.sv
// Bench for pwd_cand_gen: five differently parameterised instances checked
// every cycle against an integer-arithmetic model, plus directed literal checks.
module tb_pwd_cand_gen;

    localparam int N = 5;
    localparam logic [31:0] P_START  [N] = '{32'h00000000, 32'h00000095, 32'h99999998, 32'h00000037, 32'h00000123};
    localparam logic [31:0] P_END    [N] = '{32'h99999999, 32'h00000103, 32'h99999999, 32'h00000213, 32'h00000123};
    localparam logic [31:0] P_STRIDE [N] = '{32'h00000001, 32'h00000004, 32'h00000002, 32'h00000019, 32'h00000001};

    logic        clk;
    logic        rstn_s  [N];
    logic        start_s [N];
    logic        stop_s  [N];
    logic        ready_s [N];
    logic        valid_o [N];
    logic        busy_o  [N];
    logic        exh_o   [N];
    logic [31:0] bcd_o   [N];
    logic [63:0] asc_o   [N];
    logic [31:0] cnt_o   [N];

    int     errors = 0;
    int     checks = 0;
    bit     chk_en = 1'b0;

    // Model state: 0 idle, 1 run, 2 done; values held as plain integers.
    int     m_st  [N];
    longint m_cur [N];
    longint m_cnt [N];
    bit     m_exh [N];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        pwd_cand_gen #(
            .START_BCD  (P_START[gi]),
            .END_BCD    (P_END[gi]),
            .STRIDE_BCD (P_STRIDE[gi])
        ) u_dut (
            .clk          (clk),
            .reset_n      (rstn_s[gi]),
            .start        (start_s[gi]),
            .stop         (stop_s[gi]),
            .cand_valid   (valid_o[gi]),
            .cand_ready   (ready_s[gi]),
            .cand_bcd     (bcd_o[gi]),
            .cand_ascii   (asc_o[gi]),
            .busy         (busy_o[gi]),
            .exhausted    (exh_o[gi]),
            .issued_count (cnt_o[gi])
        );
    end

    function automatic longint bcd2int(input logic [31:0] v);
        longint r = 0;
        for (int k = 7; k >= 0; k--) r = r * 10 + longint'(v[4*k +: 4]);
        return r;
    endfunction

    function automatic logic [31:0] int2bcd(input longint v);
        logic [31:0] r;
        longint t = v;
        for (int k = 0; k < 8; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [63:0] exp_ascii(input longint v);
        logic [63:0] r;
        longint t = v;
        for (int k = 0; k < 8; k++) begin
            r[8*k +: 8] = 8'h30 + 8'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %h expected %h at %0t", name, inst, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!rstn_s[i]) begin
                m_st[i]  = 0;
                m_cur[i] = bcd2int(P_START[i]);
                m_cnt[i] = 0;
                m_exh[i] = 1'b0;
            end else if (m_st[i] != 1) begin
                if (start_s[i]) begin
                    m_st[i]  = 1;
                    m_cur[i] = bcd2int(P_START[i]);
                    m_cnt[i] = 0;
                    m_exh[i] = 1'b0;
                end
            end else begin
                if (ready_s[i]) begin
                    m_cnt[i] = (m_cnt[i] + 1) % 100000000;
                    $display("hs inst=%0d cand=%08h count=%08h", i, int2bcd(m_cur[i]), int2bcd(m_cnt[i]));
                end
                if (stop_s[i]) begin
                    m_st[i]  = 2;
                    m_exh[i] = 1'b0;
                end else if (ready_s[i]) begin
                    if (m_cur[i] + bcd2int(P_STRIDE[i]) > bcd2int(P_END[i])) begin
                        m_st[i]  = 2;
                        m_exh[i] = 1'b1;
                    end else begin
                        m_cur[i] = m_cur[i] + bcd2int(P_STRIDE[i]);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < N; i++) begin
                check("valid", i, 64'(valid_o[i]), 64'(m_st[i] == 1));
                check("busy", i, 64'(busy_o[i]), 64'(m_st[i] == 1));
                check("exhausted", i, 64'(exh_o[i]), 64'(m_exh[i]));
                check("issued_count", i, 64'(cnt_o[i]), 64'(int2bcd(m_cnt[i])));
                if (m_st[i] == 1) begin
                    check("cand_bcd", i, 64'(bcd_o[i]), 64'(int2bcd(m_cur[i])));
                    check("cand_ascii", i, asc_o[i], exp_ascii(m_cur[i]));
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start(input int i);
        start_s[i] = 1'b1;
        tick();
        start_s[i] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            rstn_s[i] = 1'b0; start_s[i] = 1'b0; stop_s[i] = 1'b0; ready_s[i] = 1'b0;
            m_st[i] = 0; m_cur[i] = 0; m_cnt[i] = 0; m_exh[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        tick();
        chk_en = 1'b1;
        check("reset_valid", 0, 64'(valid_o[0]), 64'(0));
        check("reset_count", 0, 64'(cnt_o[0]), 64'(0));
        for (int i = 0; i < N; i++) rstn_s[i] = 1'b1;
        tick();

        // Decimal counting from defaults with ready held high.
        ready_s[0] = 1'b1;
        pulse_start(0);
        check("first_cand", 0, 64'(bcd_o[0]), 64'h0);
        repeat (10) tick();
        check("cand_after_carry", 0, 64'(bcd_o[0]), 64'h00000010);
        check("ascii_00000010", 0, asc_o[0], 64'h3030303030303130);

        // Alternating ready: values must hold while ready is low.
        for (int k = 0; k < 40; k++) begin
            ready_s[0] = (k % 2 == 0);
            tick();
        end
        ready_s[0] = 1'b1;
        stop_s[0] = 1'b1;
        tick();
        stop_s[0] = 1'b0;
        check("valid_after_stop", 0, 64'(valid_o[0]), 64'(0));

        // Stop coincident with handshake on candidate 5.
        pulse_start(0);
        repeat (5) tick();
        check("cand_5", 0, 64'(bcd_o[0]), 64'h5);
        stop_s[0] = 1'b1;
        tick();
        stop_s[0] = 1'b0;
        check("stop_hs_count", 0, 64'(cnt_o[0]), 64'h6);
        check("stop_hs_exh", 0, 64'(exh_o[0]), 64'(0));
        pulse_start(0);
        check("restart_cand", 0, 64'(bcd_o[0]), 64'h0);

        // Reset mid-run at candidate 42.
        rstn_s[0] = 1'b0;
        tick();
        rstn_s[0] = 1'b1;
        pulse_start(0);
        repeat (42) tick();
        check("cand_42", 0, 64'(bcd_o[0]), 64'h42);
        rstn_s[0] = 1'b0;
        tick();
        rstn_s[0] = 1'b1;
        check("rst_valid", 0, 64'(valid_o[0]), 64'(0));
        check("rst_busy", 0, 64'(busy_o[0]), 64'(0));
        check("rst_count", 0, 64'(cnt_o[0]), 64'h0);

        // Stride 4 across a hundreds boundary up to an inclusive end.
        ready_s[1] = 1'b1;
        pulse_start(1);
        check("s4_first", 1, 64'(bcd_o[1]), 64'h95);
        tick();
        check("s4_second", 1, 64'(bcd_o[1]), 64'h99);
        tick();
        check("s4_third", 1, 64'(bcd_o[1]), 64'h103);
        tick();
        check("s4_exh", 1, 64'(exh_o[1]), 64'(1));
        check("s4_count", 1, 64'(cnt_o[1]), 64'h3);

        // Stop coincident with range end: stop wins.
        pulse_start(1);
        repeat (2) tick();
        stop_s[1] = 1'b1;
        tick();
        stop_s[1] = 1'b0;
        check("stop_end_exh", 1, 64'(exh_o[1]), 64'(0));
        check("stop_end_count", 1, 64'(cnt_o[1]), 64'h3);

        // Carry out of the top digit ends the run.
        ready_s[2] = 1'b1;
        pulse_start(2);
        check("top_cand", 2, 64'(bcd_o[2]), 64'h99999998);
        tick();
        check("top_exh", 2, 64'(exh_o[2]), 64'(1));
        check("top_count", 2, 64'(cnt_o[2]), 64'h1);

        // Start equal to end: exactly one candidate.
        ready_s[4] = 1'b1;
        pulse_start(4);
        check("single_cand", 4, 64'(bcd_o[4]), 64'h123);
        tick();
        check("single_exh", 4, 64'(exh_o[4]), 64'(1));
        check("single_count", 4, 64'(cnt_o[4]), 64'h1);

        // Start during run is ignored.
        ready_s[3] = 1'b1;
        pulse_start(3);
        check("s19_first", 3, 64'(bcd_o[3]), 64'h37);
        pulse_start(3);
        check("start_in_run", 3, 64'(bcd_o[3]), 64'h56);

        // Randomised traffic on every instance.
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < N; i++) begin
                rstn_s[i]  = ($urandom_range(0, 99) != 0);
                start_s[i] = ($urandom_range(0, 11) == 0);
                stop_s[i]  = ($urandom_range(0, 39) == 0);
                ready_s[i] = ($urandom_range(0, 2) != 0);
            end
            tick();
        end
        for (int i = 0; i < N; i++) begin
            start_s[i] = 1'b0; stop_s[i] = 1'b0; ready_s[i] = 1'b0; rstn_s[i] = 1'b1;
        end
        tick();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
